// File: rtl/constraint_eval_arbiter_pkg.sv
// Shared types and constants for the constraint evaluation arbiter.
package constraint_eval_arbiter_pkg;

  // Main control FSM states
  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StHold
  } state_e;

  // Shift amount loaded on reset
  localparam logic [2:0] ShamtRst = 3'd3;

  // Width of the saturating satisfied-result counter
  localparam int unsigned SatCountW = 16;

endpackage

// File: rtl/constraint_eval_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx
);

  // Index where the next search begins
  logic [2:0]      ptr_q;
  logic [2:0]      ptr_d;
  logic [3:0]      idx;
  logic [NREQ-1:0] rot;
  logic            found;

  // Rotating priority search starting at ptr_q, wrapping at NREQ
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    rot     = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = {1'b0, ptr_q} + 4'(i);
      if (idx >= 4'(NREQ)) begin
        idx = idx - 4'(NREQ);
      end
      rot = req >> idx;
      if (!found && rot[0]) begin
        found   = 1'b1;
        gnt     = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        gnt_idx = idx[2:0];
      end
    end
  end

  // Next search starts one past the winner
  always_comb begin
    ptr_d = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
  end

  // Pointer moves only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 3'd0;
    end else if (en) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/constraint_eval_arbiter.sv
// Arbitrates requesters, evaluates |(operand >> shamt) and holds the result
// until accepted, counting satisfied results.
module constraint_eval_arbiter
  import constraint_eval_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_shamt,
  output logic                 cfg_busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic                 rsp_sat,
  output logic [SatCountW-1:0] sat_count
);

  state_e               state_q, state_d;
  logic [DW-1:0]        operand_q;
  logic [DW-1:0]        operand_sel;
  logic [2:0]           id_q;
  logic [2:0]           shamt_q;
  logic                 rsp_valid_q;
  logic [2:0]           rsp_id_q;
  logic                 rsp_sat_q;
  logic [SatCountW-1:0] sat_count_q;
  logic [NREQ-1:0]      gnt;
  logic [2:0]           gnt_idx;
  logic                 grant;
  logic                 handshake;
  logic                 eval_sat;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (grant),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // Grant/handshake decode, operand select and constraint evaluation
  always_comb begin
    grant       = !rst && (state_q == StIdle) && (|req_valid);
    handshake   = (state_q == StHold) && rsp_valid_q && rsp_ready;
    operand_sel = DW'(req_data >> (32'(gnt_idx) * DW));
    // Shifts of DW or more clear every bit
    eval_sat    = (32'(shamt_q) >= DW) ? 1'b0 : |(operand_q >> shamt_q);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StEval;
      StEval:  state_d = StHold;
      StHold:  if (handshake) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand capture, config, registered response and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      operand_q   <= '0;
      id_q        <= '0;
      shamt_q     <= ShamtRst;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q <= state_d;
      // A write coinciding with a grant lands before EVAL reads shamt_q
      if (cfg_we && (state_q == StIdle)) begin
        shamt_q <= cfg_shamt;
      end
      if (grant) begin
        operand_q <= operand_sel;
        id_q      <= gnt_idx;
      end
      if (state_q == StEval) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_sat_q   <= eval_sat;
      end else if (handshake) begin
        rsp_valid_q <= 1'b0;
      end
      if (handshake && rsp_sat_q && (sat_count_q != '1)) begin
        sat_count_q <= sat_count_q + {{(SatCountW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Output drive
  always_comb begin
    req_ready = grant ? gnt : '0;
    cfg_busy  = (state_q != StIdle);
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_sat   = rsp_sat_q;
    sat_count = sat_count_q;
  end

endmodule
